// File: rtl/game_pkg.sv
// Shared constants and types for the game front-end.
// Button/field indices, poller state encoding and button decode.
package game_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int IN_UP     = 0;
  localparam int IN_DOWN   = 1;
  localparam int IN_LEFT   = 2;
  localparam int IN_RIGHT  = 3;
  localparam int IN_ATTACK = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_CLK_HI = 3'd4,
    ST_DONE   = 3'd5
  } poll_state_e;

  // Opposing directions cancel each other out.
  function automatic logic [4:0] decode_btn(
    input logic [7:0] b
  );
    logic [4:0] r;
    r            = '0;
    r[IN_ATTACK] = b[BTN_A];
    r[IN_UP]     = b[BTN_UP] & ~b[BTN_DOWN];
    r[IN_DOWN]   = b[BTN_DOWN] & ~b[BTN_UP];
    r[IN_LEFT]   = b[BTN_LEFT] & ~b[BTN_RIGHT];
    r[IN_RIGHT]  = b[BTN_RIGHT] & ~b[BTN_LEFT];
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pad inputs.
// Reset value is a parameter so idle-high pads read as released.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gamepad_reader.sv
// NES-style serial pad poller: latch, clock out 8 bits,
// decode into the 5-bit player input word once per frame.
module gamepad_reader
  import game_pkg::*;
#(
  parameter int unsigned HALF = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons_raw,
  output logic [4:0] input_data,
  output logic       input_valid
);

  localparam logic [9:0] HALF_M1 = 10'(HALF - 1);

  poll_state_e state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        half_q, half_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buttons_q, buttons_d;
  logic [4:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        latch_q, latch_d;
  logic        pclk_q, pclk_d;
  logic        pad_s;
  logic        last;
  logic        sample;
  logic        fin;
  logic [7:0]  btn_new;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (pad_data),
    .q    (pad_s)
  );

  assign last    = (cnt_q == 10'd0);
  assign sample  = last && (state_q == ST_SETTLE ||
                            state_q == ST_CLK_HI);
  assign fin     = last && (state_q == ST_CLK_HI) &&
                   (idx_q == 3'd7);
  assign btn_new = ~{pad_s, shift_q[7:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (frame_end) state_d = ST_LATCH;
      ST_LATCH:  if (last && half_q) state_d = ST_SETTLE;
      ST_SETTLE: if (last) state_d = ST_CLK_LO;
      ST_CLK_LO: if (last) state_d = ST_CLK_HI;
      ST_CLK_HI: if (last) begin
        state_d = (idx_q == 3'd7) ? ST_DONE : ST_CLK_LO;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pad pins are registered from the next state to stay glitch-free.
  always_comb begin
    latch_d = 1'b0;
    pclk_d  = 1'b1;
    unique case (state_d)
      ST_LATCH:  latch_d = 1'b1;
      ST_CLK_LO: pclk_d  = 1'b0;
      default: begin
        latch_d = 1'b0;
        pclk_d  = 1'b1;
      end
    endcase
  end

  // LATCH spans two counter loads so HALF up to 1023 fits 10 bits.
  always_comb begin
    cnt_d   = last ? cnt_q : cnt_q - 10'd1;
    half_d  = half_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_d != state_q) cnt_d = HALF_M1;
    if (state_q == ST_LATCH && last && !half_q) begin
      cnt_d  = HALF_M1;
      half_d = 1'b1;
    end
    if (state_q == ST_IDLE) begin
      half_d = 1'b0;
      idx_d  = 3'd0;
    end
    if (sample) begin
      shift_d = {pad_s, shift_q[7:1]};
      idx_d   = idx_q + 3'd1;
    end
  end

  always_comb begin
    buttons_d = buttons_q;
    data_d    = data_q;
    valid_d   = fin;
    if (fin) begin
      buttons_d = btn_new;
      data_d    = decode_btn(btn_new);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      half_q    <= 1'b0;
      idx_q     <= '0;
      shift_q   <= '1;
      buttons_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
    end
  end

  assign pad_latch   = latch_q;
  assign pad_clk     = pclk_q;
  assign buttons_raw = buttons_q;
  assign input_data  = data_q;
  assign input_valid = valid_q;

endmodule

// File: tb/tb_gamepad_reader.sv
// Directed bench for gamepad_reader with a shift-register pad model.
// HALF=4: a poll completes with input_valid at cycle 69.
module tb_gamepad_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_end = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons_raw;
  logic [4:0] input_data;
  logic       input_valid;

  logic [7:0] btns = 8'h00;
  logic       unplug = 1'b0;
  logic [7:0] sr = 8'hFF;
  logic       mprev = 1'b1;

  int tests = 0;
  int fails = 0;

  int lat_hi = 0;
  int clk_low = 0;
  int clk_falls = 0;
  logic wprev = 1'b1;

  int s_lat, s_low, s_falls;

  gamepad_reader #(.HALF(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_end  (frame_end),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons_raw(buttons_raw),
    .input_data (input_data),
    .input_valid(input_valid)
  );

  always #5 clk = ~clk;

  // Controller: loads while latch high, shifts on pad_clk rise.
  always @(posedge clk) begin
    if (pad_latch) sr <= ~btns;
    else if (pad_clk && !mprev) sr <= {1'b1, sr[7:1]};
    mprev <= pad_clk;
  end

  assign pad_data = unplug ? 1'b1 : sr[0];

  always @(negedge clk) begin
    if (pad_latch) lat_hi = lat_hi + 1;
    if (!pad_clk) clk_low = clk_low + 1;
    if (wprev && !pad_clk) clk_falls = clk_falls + 1;
    wprev = pad_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves time just after the edge that opens cycle 1.
  task automatic start();
    @(posedge clk);
    #1;
    frame_end = 1'b1;
    s_lat   = lat_hi;
    s_low   = clk_low;
    s_falls = clk_falls;
    @(posedge clk);
    #1;
    frame_end = 1'b0;
  endtask

  task automatic poll(input string tag,
                      input logic [7:0] b,
                      input logic [4:0] ed,
                      input logic [7:0] er);
    btns = b;
    start();
    chk({tag, "_latch_rise"}, pad_latch, 1);
    cyc(67);
    chk({tag, "_valid_c68"}, input_valid, 0);
    cyc(1);
    chk({tag, "_valid_c69"}, input_valid, 1);
    chk({tag, "_data"}, input_data, ed);
    chk({tag, "_raw"}, buttons_raw, er);
    cyc(1);
    chk({tag, "_valid_c70"}, input_valid, 0);
    chk({tag, "_data_hold"}, input_data, ed);
    chk({tag, "_latch_cycles"}, lat_hi - s_lat, 8);
    chk({tag, "_clk_pulses"}, clk_falls - s_falls, 7);
    chk({tag, "_clk_low_cyc"}, clk_low - s_low, 28);
  endtask

  initial begin
    cyc(3);
    chk("rst_latch", pad_latch, 0);
    chk("rst_pclk", pad_clk, 1);
    chk("rst_raw", buttons_raw, 0);
    chk("rst_data", input_data, 0);
    chk("rst_valid", input_valid, 0);
    reset = 1'b1;
    cyc(2);
    chk("idle_latch", pad_latch, 0);

    poll("up", 8'h10, 5'b00001, 8'h10);
    poll("diag", 8'hA1, 5'b11010, 8'hA1);

    // Abort mid-poll at cycle 40
    btns = 8'h10;
    start();
    cyc(39);
    chk("mid_pclk_low", pad_clk, 0);
    reset = 1'b0;
    #1;
    chk("mid_latch", pad_latch, 0);
    chk("mid_pclk", pad_clk, 1);
    chk("mid_data", input_data, 0);
    chk("mid_raw", buttons_raw, 0);
    chk("mid_valid", input_valid, 0);
    cyc(3);
    reset = 1'b1;
    cyc(2);

    poll("oppose", 8'hF8, 5'b00000, 8'hF8);

    // Unplugged pad with a second frame_end at cycle 30
    unplug = 1'b1;
    btns = 8'hFF;
    start();
    cyc(29);
    frame_end = 1'b1;
    cyc(1);
    frame_end = 1'b0;
    cyc(37);
    chk("unplug_valid_c68", input_valid, 0);
    cyc(1);
    chk("unplug_valid", input_valid, 1);
    chk("unplug_data", input_data, 0);
    chk("unplug_raw", buttons_raw, 0);
    s_lat = lat_hi;
    cyc(40);
    chk("unplug_no_requeue", lat_hi - s_lat, 0);
    chk("unplug_valid_quiet", input_valid, 0);
    unplug = 1'b0;

    // frame_end in DONE ignored, in following IDLE accepted
    btns = 8'h01;
    start();
    cyc(68);
    chk("coin_valid", input_valid, 1);
    chk("coin_data", input_data, 5'b10000);
    frame_end = 1'b1;
    cyc(1);
    chk("coin_done_ignored", pad_latch, 0);
    btns = 8'h40;
    cyc(1);
    frame_end = 1'b0;
    chk("coin_idle_start", pad_latch, 1);
    chk("coin_data_hold", input_data, 5'b10000);
    cyc(68);
    chk("coin2_valid", input_valid, 1);
    chk("coin2_data", input_data, 5'b00100);
    chk("coin2_raw", buttons_raw, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
